// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and its next-PC calculator.
// Holds the opcode map, the instruction field positions and the fetch FSM
// state encoding. It has no ports.
package cpu_pkg;

  // Opcode map, decoded from instr[OPC_HI:OPC_LO].
  typedef enum logic [3:0] {
    OP_LOAD    = 4'b0000,
    OP_STORE   = 4'b0001,
    OP_JUMP    = 4'b0010,
    OP_BRANCHZ = 4'b0100,
    OP_TYPEC   = 4'b1000,
    OP_ADDI    = 4'b1100,
    OP_SUBI    = 4'b1101,
    OP_ANDI    = 4'b1110,
    OP_ORI     = 4'b1111
  } opcode_e;

  // Instruction field positions.
  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 12;
  localparam int JADDR_W  = 12;
  localparam int BR_OFF_W = 8;

  // Fetch FSM state encoding.
  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] EXEC  = 1'b1;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and
// instruction memory.
//   imem_req   : fetch stage requests the word at imem_addr
//   imem_addr  : word address of the requested instruction
//   imem_ack   : memory returns imem_rdata this cycle
//   imem_rdata : instruction word, valid while imem_ack is high
// The master modport belongs to the fetch stage and the slave modport to the memory.
interface fetch_pc_unit_if #(
  parameter int PC_W    = 12,
  parameter int INSTR_W = 16
);

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the fetch stage.
// Inputs : pc, instr, pc_sel, branch_sel, jump_sel, zero
// Outputs: next_pc  - the PC to fetch after the current instruction
//          pc_plus1 - pc + 1, wrapping modulo 2^PC_W
// Priority is jump first, then a taken branch, then sequential. The
// sequential case also covers undefined opcodes where no select is raised.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int PC_W     = 12,
  parameter int INSTR_W  = 16,
  parameter int BR_OFF_W = cpu_pkg::BR_OFF_W
) (
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               pc_sel,
  input  logic               branch_sel,
  input  logic               jump_sel,
  input  logic               zero,
  output logic [PC_W-1:0]    next_pc,
  output logic [PC_W-1:0]    pc_plus1
);

  logic [PC_W-1:0] jump_target;
  logic [PC_W-1:0] br_off_ext;
  logic [PC_W-1:0] branch_target;

  // pc_sel only names the default path, and the opcode bits are decoded by the CU.
  logic unused_fields;
  assign unused_fields = ^{pc_sel, instr[INSTR_W-1:JADDR_W]};

  assign pc_plus1 = pc + {{(PC_W-1){1'b0}}, 1'b1};

  // The branch offset is signed. Its sum wraps naturally at PC_W bits.
  assign br_off_ext    = {{(PC_W-BR_OFF_W){instr[BR_OFF_W-1]}}, instr[BR_OFF_W-1:0]};
  assign branch_target = pc_plus1 + br_off_ext;

  // A jump replaces only the low JADDR_W bits. Any wider PC keeps its page bits.
  generate
    if (PC_W > JADDR_W) begin : g_paged_jump
      assign jump_target = {pc[PC_W-1:JADDR_W], instr[JADDR_W-1:0]};
    end else begin : g_flat_jump
      assign jump_target = instr[PC_W-1:0];
    end
  endgenerate

  always_comb begin
    next_pc = pc_plus1;
    if (jump_sel) begin
      next_pc = jump_target;
    end else if (branch_sel && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction fetch stage. It owns the PC and the instruction register.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   imem          : instruction memory bus (master side)
//   instr, opcode : latched instruction and its opcode field, sent to the CU
//   instr_valid   : instr is held stable while the datapath executes it
//   exec_done     : datapath finished; pc_sel/branch_sel/jump_sel/zero are valid
//   pc, pc_plus1  : current PC and its successor
// The unit alternates between two states. FETCH holds the request until
// memory acknowledges it. EXEC holds the instruction until exec_done.
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 12,
  parameter int              INSTR_W  = 16,
  parameter int              BR_OFF_W = cpu_pkg::BR_OFF_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_pc_unit_if.master       imem,
  output logic [INSTR_W-1:0]    instr,
  output logic [3:0]            opcode,
  output logic                  instr_valid,
  input  logic                  exec_done,
  input  logic                  pc_sel,
  input  logic                  branch_sel,
  input  logic                  jump_sel,
  input  logic                  zero,
  output logic [PC_W-1:0]       pc,
  output logic [PC_W-1:0]       pc_plus1
);

  logic [0:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    next_pc;

  next_pc_calc #(
    .PC_W     (PC_W),
    .INSTR_W  (INSTR_W),
    .BR_OFF_W (BR_OFF_W)
  ) u_next_pc_calc (
    .pc         (pc_q),
    .instr      (instr_q),
    .pc_sel     (pc_sel),
    .branch_sel (branch_sel),
    .jump_sel   (jump_sel),
    .zero       (zero),
    .next_pc    (next_pc),
    .pc_plus1   (pc_plus1)
  );

  // An ack counts only in FETCH, and exec_done counts only in EXEC.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      FETCH: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (exec_done) begin
          pc_d    = next_pc;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // rst masks the handshake outputs during the reset cycle itself, so no
  // request is issued while an older state is still being cleared.
  assign imem.imem_req  = (state_q == FETCH) && !rst;
  assign imem.imem_addr = pc_q;
  assign instr_valid    = (state_q == EXEC) && !rst;
  assign instr          = instr_q;
  assign opcode         = instr_q[INSTR_W-1 -: (OPC_HI-OPC_LO+1)];
  assign pc             = pc_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Testbench for fetch_pc_unit. It uses directed vectors with hand-computed
// next-PC values, plus hand-written sequences for reset, memory wait states
// and ignored handshakes.
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic        instr_valid;
  logic        exec_done;
  logic        pc_sel;
  logic        branch_sel;
  logic        jump_sel;
  logic        zero;
  logic [11:0] pc;
  logic [11:0] pc_plus1;

  int checks;
  int errors;

  fetch_pc_unit_if #(.PC_W(12), .INSTR_W(16)) bus ();

  fetch_pc_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .pc_sel      (pc_sel),
    .branch_sel  (branch_sel),
    .jump_sel    (jump_sel),
    .zero        (zero),
    .pc          (pc),
    .pc_plus1    (pc_plus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] start_pc;
    logic [15:0] word;
    logic        ps;
    logic        br;
    logic        jp;
    logic        z;
    logic [11:0] exp_pc;
    string       name;
  } vec_t;

  vec_t vecs [11];

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic d, input logic ps, input logic br,
                               input logic jp, input logic z);
    exec_done  = d;
    pc_sel     = ps;
    branch_sel = br;
    jump_sel   = jp;
    zero       = z;
  endtask

  // Run one instruction from FETCH: ack it immediately, check EXEC, then
  // complete it and check the next fetch address.
  task automatic runInstr(input logic [15:0] word, input logic ps, input logic br,
                          input logic jp, input logic z, input logic [11:0] exp_addr,
                          input string tag);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    step();
    bus.imem_ack   = 1'b0;
    checkOutput({tag, "_valid"}, {15'd0, instr_valid}, 16'd1);
    checkOutput({tag, "_req_low"}, {15'd0, bus.imem_req}, 16'd0);
    checkOutput({tag, "_instr"}, instr, word);
    checkOutput({tag, "_opcode"}, {12'd0, opcode}, {12'd0, word[15:12]});
    applyStimulus(1'b1, ps, br, jp, z);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_req"}, {15'd0, bus.imem_req}, 16'd1);
    checkOutput({tag, "_addr"}, {4'd0, bus.imem_addr}, {4'd0, exp_addr});
    checkOutput({tag, "_pc"}, {4'd0, pc}, {4'd0, exp_addr});
    checkOutput({tag, "_valid_low"}, {15'd0, instr_valid}, 16'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 16'h0000;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    vecs[0]  = '{12'h00A, 16'h40FD, 1'b0, 1'b1, 1'b0, 1'b1, 12'h008, "br_neg_taken"};
    vecs[1]  = '{12'h00A, 16'h40FD, 1'b0, 1'b1, 1'b0, 1'b0, 12'h00B, "br_not_taken"};
    vecs[2]  = '{12'hFFE, 16'h4005, 1'b0, 1'b1, 1'b0, 1'b1, 12'h004, "br_wrap"};
    vecs[3]  = '{12'h123, 16'h2ABC, 1'b0, 1'b0, 1'b1, 1'b0, 12'hABC, "jump"};
    vecs[4]  = '{12'h123, 16'h2ABC, 1'b0, 1'b1, 1'b1, 1'b1, 12'hABC, "jump_over_br"};
    vecs[5]  = '{12'hFFF, 16'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, "inc_wrap"};
    vecs[6]  = '{12'h050, 16'h3000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h051, "no_select"};
    vecs[7]  = '{12'h020, 16'h4080, 1'b0, 1'b1, 1'b0, 1'b1, 12'hFA1, "br_min_off"};
    vecs[8]  = '{12'h7F0, 16'h407F, 1'b0, 1'b1, 1'b0, 1'b1, 12'h870, "br_max_off"};
    vecs[9]  = '{12'h100, 16'hC0FF, 1'b1, 1'b0, 1'b0, 1'b1, 12'h101, "addi_seq"};
    vecs[10] = '{12'h200, 16'h2FFF, 1'b0, 1'b0, 1'b1, 1'b0, 12'hFFF, "jump_top"};

    // Hold reset for two cycles and check the reset state.
    step();
    step();
    checkOutput("rst_pc", {4'd0, pc}, 16'h0000);
    checkOutput("rst_pc_plus1", {4'd0, pc_plus1}, 16'h0001);
    checkOutput("rst_req", {15'd0, bus.imem_req}, 16'd0);
    checkOutput("rst_valid", {15'd0, instr_valid}, 16'd0);
    checkOutput("rst_instr", instr, 16'h0000);
    rst = 1'b0;
    #1;
    checkOutput("rel_req", {15'd0, bus.imem_req}, 16'd1);
    checkOutput("rel_addr", {4'd0, bus.imem_addr}, 16'h0000);

    // Sequential fetch with immediate ack and exec_done.
    for (int i = 0; i < 4; i++) begin
      runInstr(16'h1000 + 16'(i), 1'b1, 1'b0, 1'b0, 1'b0, 12'(i + 1), "seq");
    end

    // Memory wait states at pc=5.
    runInstr(16'h2005, 1'b0, 1'b0, 1'b1, 1'b0, 12'h005, "to5");
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("wait_req", {15'd0, bus.imem_req}, 16'd1);
      checkOutput("wait_addr", {4'd0, bus.imem_addr}, 16'h0005);
      checkOutput("wait_valid", {15'd0, instr_valid}, 16'd0);
      checkOutput("wait_instr", instr, 16'h2005);
    end
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 16'hC123;
    step();
    checkOutput("wait_ack_valid", {15'd0, instr_valid}, 16'd1);
    checkOutput("wait_ack_instr", instr, 16'hC123);
    // An ack during EXEC must not reload instr.
    bus.imem_rdata = 16'hFFFF;
    step();
    bus.imem_ack = 1'b0;
    checkOutput("exec_ack_ignored", instr, 16'hC123);
    checkOutput("exec_hold_valid", {15'd0, instr_valid}, 16'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("wait_next_addr", {4'd0, bus.imem_addr}, 16'h0006);
    // An exec_done during FETCH must not move the pc.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("fetch_done_ignored", {4'd0, bus.imem_addr}, 16'h0006);
    checkOutput("fetch_done_req", {15'd0, bus.imem_req}, 16'd1);

    // Reset while FETCH is waiting. The ack in the same cycle is discarded.
    rst = 1'b1;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 16'hFFFF;
    step();
    checkOutput("rstf_pc", {4'd0, pc}, 16'h0000);
    checkOutput("rstf_req", {15'd0, bus.imem_req}, 16'd0);
    checkOutput("rstf_valid", {15'd0, instr_valid}, 16'd0);
    checkOutput("rstf_instr", instr, 16'h0000);
    rst = 1'b0;
    bus.imem_ack = 1'b0;
    #1;
    checkOutput("rstf_rel_req", {15'd0, bus.imem_req}, 16'd1);
    checkOutput("rstf_rel_addr", {4'd0, bus.imem_addr}, 16'h0000);

    // Reset while in EXEC with exec_done raised.
    runInstr(16'h2040, 1'b0, 1'b0, 1'b1, 1'b0, 12'h040, "to40");
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 16'h2123;
    step();
    bus.imem_ack = 1'b0;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rste_pc", {4'd0, pc}, 16'h0000);
    checkOutput("rste_valid", {15'd0, instr_valid}, 16'd0);
    checkOutput("rste_req", {15'd0, bus.imem_req}, 16'd0);
    checkOutput("rste_instr", instr, 16'h0000);
    rst = 1'b0;
    #1;
    checkOutput("rste_rel_req", {15'd0, bus.imem_req}, 16'd1);

    // Table of next-PC cases. Each reaches its start pc with a jump first.
    for (int i = 0; i < 11; i++) begin
      runInstr(16'h2000 | {4'd0, vecs[i].start_pc}, 1'b0, 1'b0, 1'b1, 1'b0,
               vecs[i].start_pc, {vecs[i].name, "_setup"});
      runInstr(vecs[i].word, vecs[i].ps, vecs[i].br, vecs[i].jp, vecs[i].z,
               vecs[i].exp_pc, vecs[i].name);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
